fwd_source_pipe: RTL and testbench
==================================

Name: fwd_source_pipe

Overview:
- Producer side of the D-stage forwarding path: carries instructions and their results through the E/M/W pipeline registers.
- Drives the instrE/instrM/instrW buses and the M/W result values that the branch and ALU forwarding muxes select from.
- Detects when a needed value does not yet exist in M or W, then stalls D and inserts a bubble into E.
- Sits between the decode-stage register and the register file write port.

Parameters:
- STALL_CNT_W, 16, width of the saturating stall-cycle performance counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instrD  in  32  instruction currently in D.
- res_E  in  32  E-stage result: ALU output, or PC+8 for jal.
- mem_rdata_M  in  32  data-memory read data for the instruction in M.
- instrE  out  32  registered instruction in E.
- instrM  out  32  registered instruction in M.
- instrW  out  32  registered instruction in W.
- fwd_data_M  out  32  result held in M (res_E captured the prior cycle).
- fwd_data_W  out  32  result held in W (load data or fwd_data_M).
- stall_D  out  1  combinational; holds PC and the IF/ID register when 1.
- we_W  out  1  register-file write enable.
- waddr_W  out  5  register-file write address.
- wdata_W  out  32  register-file write data; equals fwd_data_W.
- stall_cnt  out  STALL_CNT_W  saturating count of stalled cycles.

Behaviour:
- Instruction classes: cal_r (op 0, funct addu/subu), cal_i (ori/lui/addiu), load (lw), store (sw), beq, jal, jr (op 0, funct 0x08).
- Destination of an instruction: cal_r uses rd, cal_i/load use rt, jal uses 31. All others have destination 0 ("no write").
- Reset (rst_n=0, asynchronous):
  - instrE/M/W = 0 (nop), fwd_data_M/W = 0, stall_cnt = 0.
  - stall_D is therefore 0, and we_W = 0, waddr_W = 0.
- Each rising edge, no stall:
  - instrE<=instrD, instrM<=instrE, instrW<=instrM.
  - fwd_data_M<=res_E.
  - fwd_data_W<=mem_rdata_M if instrM is a load, else fwd_data_M.
- Each rising edge, stall_D=1:
  - instrE<=0 (bubble).
  - M and W still advance as above.
  - D is held externally.
  - stall_cnt increments, saturating at all-ones.
- Stall conditions (any one asserts stall_D). Let r be rs_D or rt_D, and r must be nonzero.
  - (a) instrD is beq/jr, r is read by it, and dst(instrE)==r.
  - (b) instrD is beq/jr, instrM is a load, and dst(instrM)==r.
  - (c) instrD is cal_r/cal_i/load/store, instrE is a load, and dst(instrE)==r. Only registers the D instruction actually reads count:
    - cal_i and load read rs only.
    - cal_r, beq and store read rs and rt.
    - jr reads rs only.
- A dependence on $0 never stalls. A destination of 0 never matches.
- Latency: a stall lasts 1 cycle for cases (b) and (c). Case (a) with a load in E lasts 2 cycles: (a) in the first cycle, then (b) in the next.
- we_W = (dst(instrW) != 0). waddr_W = dst(instrW).
- Back-to-back stalls are legal. stall_cnt holds at max and never wraps.
- Reset asserted mid-stall clears the bubble state at once; stall_D drops in the same cycle.

Decomposition:
- Shared package mips_defs holds:
  - opcode constants: OP_SPECIAL=0x00, OP_BEQ=0x04, OP_JAL=0x03, OP_ADDIU=0x09, OP_ORI=0x0d, OP_LUI=0x0f, OP_LW=0x23, OP_SW=0x2b;
  - funct constants: F_ADDU=0x21, F_SUBU=0x23, F_JR=0x08;
  - field slice positions;
  - REG_RA=31.
- One sub-module, instr_class: pure decode of one instruction into class flags, rs, rt and dst. Instantiate it once per stage (D, E, M, W).

Test Plan:
- Reset: rst_n=0 for 3 cycles with random instrD -> instrE/M/W=0, stall_D=0, we_W=0, stall_cnt=0; outputs stay stable through the rst_n release edge.
- Straight-line ALU ops: ori $1,$0,5 then addu $2,$1,$1 with res_E=5 then 10 -> no stall; fwd_data_M=5 one cycle later; wdata_W=5, waddr_W=1, we_W=1 two cycles later.
- Load-use: lw $3 in E, addu $4,$3,$3 in D -> stall_D=1 for exactly 1 cycle; instrE=0 next edge; stall_cnt=1; after the stall, wdata_W=mem_rdata_M value 0xDEADBEEF.
- Branch after load: lw $5 in E, beq $5,$0 in D -> stall_D=1 for 2 consecutive cycles (cases a then b); stall_cnt=2.
- Zero register: ori $0,$0,7 in E, beq $0,$0 in D -> stall_D=0; we_W=0 when ori reaches W.
- jal then jr $31: jal in E with res_E=PC+8=0x3008 -> 1-cycle stall; fwd_data_M=0x3008 while jr is in D; waddr_W=31.
- Counter saturation: with STALL_CNT_W=2, force 5 stall cycles -> stall_cnt sequence 1,2,3,3,3.

Source files
------------

// File: rtl/mips_defs.sv
// Shared MIPS decode constants and per-stage decode records for the forwarding pipe.
// Latency: none (constants, types and a pure helper function only).
// Backpressure: not applicable.
package mips_defs;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_JR   = 6'h08;

  // Instruction field positions (MSB/LSB).
  localparam int OP_HI    = 31;
  localparam int OP_LO    = 26;
  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 11;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;

  localparam logic [4:0] REG_RA = 5'd31;

  typedef struct packed {
    logic cal_r;
    logic cal_i;
    logic load;
    logic store;
    logic beq;
    logic jal;
    logic jr;
  } iclass_t;

  typedef struct packed {
    iclass_t    cls;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dst;    // 0 means the instruction writes nothing
    logic       rd_rs;  // rs is a real source operand
    logic       rd_rt;  // rt is a real source operand
  } idec_t;

  // A source register depends on a destination only when both are the same nonzero register.
  function automatic logic reg_hit(input logic [4:0] src, input logic [4:0] dst);
    return (src != 5'd0) && (src == dst);
  endfunction

endpackage

// File: rtl/instr_class.sv
// Pure decode of one instruction into class flags, source registers and destination.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows input every cycle.
module instr_class
  import mips_defs::*;
(
  input  logic [31:0] instr,
  output idec_t       dec
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rd;
  logic       unused_shamt_imm;

  assign op    = instr[OP_HI:OP_LO];
  assign funct = instr[FUNCT_HI:FUNCT_LO];
  assign rd    = instr[RD_HI:RD_LO];
  assign unused_shamt_imm = ^instr[10:6];

  // Classify the instruction, then derive which fields it reads and where it writes.
  always_comb begin
    dec           = '0;
    dec.rs        = instr[RS_HI:RS_LO];
    dec.rt        = instr[RT_HI:RT_LO];
    dec.cls.cal_r = (op == OP_SPECIAL) && ((funct == F_ADDU) || (funct == F_SUBU));
    dec.cls.jr    = (op == OP_SPECIAL) && (funct == F_JR);
    dec.cls.cal_i = (op == OP_ORI) || (op == OP_LUI) || (op == OP_ADDIU);
    dec.cls.load  = (op == OP_LW);
    dec.cls.store = (op == OP_SW);
    dec.cls.beq   = (op == OP_BEQ);
    dec.cls.jal   = (op == OP_JAL);

    dec.rd_rs = dec.cls.cal_r | dec.cls.cal_i | dec.cls.load | dec.cls.store
              | dec.cls.beq | dec.cls.jr;
    dec.rd_rt = dec.cls.cal_r | dec.cls.store | dec.cls.beq;

    if (dec.cls.cal_r)
      dec.dst = rd;
    else if (dec.cls.cal_i || dec.cls.load)
      dec.dst = dec.rt;
    else if (dec.cls.jal)
      dec.dst = REG_RA;
    else
      dec.dst = 5'd0;
  end

endmodule

// File: rtl/fwd_source_pipe.sv
// Carries instructions and results through E/M/W, feeds forwarding sources, detects D-stage hazards.
// Latency: one cycle per stage; stall_D is combinational from instrD and the E/M registers.
// Backpressure: stall_D holds D externally and injects a nop bubble into E; M and W always advance.
module fwd_source_pipe
  import mips_defs::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            instrD,
  input  logic [31:0]            res_E,
  input  logic [31:0]            mem_rdata_M,
  output logic [31:0]            instrE,
  output logic [31:0]            instrM,
  output logic [31:0]            instrW,
  output logic [31:0]            fwd_data_M,
  output logic [31:0]            fwd_data_W,
  output logic                   stall_D,
  output logic                   we_W,
  output logic [4:0]             waddr_W,
  output logic [31:0]            wdata_W,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  idec_t dec_d, dec_e, dec_m, dec_w;
  logic  branch_d, alu_d;
  logic  hit_e, hit_m;
  logic  stall_a, stall_b, stall_c;
  logic  unused_dec;

  instr_class u_dec_d (.instr(instrD), .dec(dec_d));
  instr_class u_dec_e (.instr(instrE), .dec(dec_e));
  instr_class u_dec_m (.instr(instrM), .dec(dec_m));
  instr_class u_dec_w (.instr(instrW), .dec(dec_w));

  // Only the destination and load flag matter downstream of D.
  assign unused_dec = ^{dec_w.cls, dec_w.rs, dec_w.rt, dec_w.rd_rs, dec_w.rd_rt,
                        dec_m.rs, dec_m.rt, dec_m.rd_rs, dec_m.rd_rt,
                        dec_e.rs, dec_e.rt, dec_e.rd_rs, dec_e.rd_rt,
                        dec_d.dst, dec_d.cls.jal};

  assign branch_d = dec_d.cls.beq | dec_d.cls.jr;
  assign alu_d    = dec_d.cls.cal_r | dec_d.cls.cal_i | dec_d.cls.load | dec_d.cls.store;

  // Does any register D actually reads match the destination in E or in M?
  assign hit_e = (dec_d.rd_rs && reg_hit(dec_d.rs, dec_e.dst))
              || (dec_d.rd_rt && reg_hit(dec_d.rt, dec_e.dst));
  assign hit_m = (dec_d.rd_rs && reg_hit(dec_d.rs, dec_m.dst))
              || (dec_d.rd_rt && reg_hit(dec_d.rt, dec_m.dst));

  // Branches resolve in D, so they wait for any producer in E and for load data still in M.
  assign stall_a = branch_d & hit_e;
  assign stall_b = branch_d & dec_m.cls.load & hit_m;
  // ALU/memory ops can take anything from M/W, but not a load still in E.
  assign stall_c = alu_d & dec_e.cls.load & hit_e;
  assign stall_D = stall_a | stall_b | stall_c;

  assign we_W    = (dec_w.dst != 5'd0);
  assign waddr_W = dec_w.dst;
  assign wdata_W = fwd_data_W;

  // Advance the pipeline registers; a stall replaces the E entry with a nop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instrE     <= '0;
      instrM     <= '0;
      instrW     <= '0;
      fwd_data_M <= '0;
      fwd_data_W <= '0;
    end else begin
      instrE     <= stall_D ? 32'd0 : instrD;
      instrM     <= instrE;
      instrW     <= instrM;
      fwd_data_M <= res_E;
      fwd_data_W <= dec_m.cls.load ? mem_rdata_M : fwd_data_M;
    end
  end

  // Count stalled cycles, holding at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (stall_D && (stall_cnt != {STALL_CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
  end

endmodule

// File: tb/tb_fwd_source_pipe.sv
// Self-checking bench for fwd_source_pipe against an instruction-level pipeline model.
// Latency: the model advances one stage per clock, like the design.
// Backpressure: the bench holds instrD while the model predicts a stall.
module tb_fwd_source_pipe;

  localparam int K_NONE = 0, K_R = 1, K_I = 2, K_LD = 3, K_ST = 4, K_BEQ = 5, K_JAL = 6, K_JR = 7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instrD = '0, res_E = '0, mem_rdata_M = '0;

  logic [31:0] instrE, instrM, instrW, fwd_data_M, fwd_data_W, wdata_W;
  logic        stall_D, we_W;
  logic [4:0]  waddr_W;
  logic [15:0] stall_cnt;

  logic [31:0] unused2_instrE, unused2_instrM, unused2_instrW, unused2_fwd_M, unused2_fwd_W, unused2_wdata;
  logic        unused2_we, stall2_D;
  logic [4:0]  unused2_waddr;
  logic [1:0]  stall2_cnt;

  int total = 0;
  int bad = 0;

  logic [31:0] m_e, m_m, m_w, m_fm, m_fw;
  int          m_cnt;
  bit          m_stall;

  always #5 clk = ~clk;

  fwd_source_pipe #(.STALL_CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .instrD(instrD), .res_E(res_E), .mem_rdata_M(mem_rdata_M),
    .instrE(instrE), .instrM(instrM), .instrW(instrW), .fwd_data_M(fwd_data_M),
    .fwd_data_W(fwd_data_W), .stall_D(stall_D), .we_W(we_W), .waddr_W(waddr_W),
    .wdata_W(wdata_W), .stall_cnt(stall_cnt)
  );

  fwd_source_pipe #(.STALL_CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .instrD(instrD), .res_E(res_E), .mem_rdata_M(mem_rdata_M),
    .instrE(unused2_instrE), .instrM(unused2_instrM), .instrW(unused2_instrW),
    .fwd_data_M(unused2_fwd_M), .fwd_data_W(unused2_fwd_W), .stall_D(stall2_D),
    .we_W(unused2_we), .waddr_W(unused2_waddr), .wdata_W(unused2_wdata), .stall_cnt(stall2_cnt)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int k_of(input logic [31:0] i);
    logic [5:0] op, fn;
    op = i[31:26];
    fn = i[5:0];
    case (op)
      6'h00:   if (fn == 6'h21 || fn == 6'h23) return K_R;
               else if (fn == 6'h08) return K_JR;
               else return K_NONE;
      6'h09, 6'h0d, 6'h0f: return K_I;
      6'h23:   return K_LD;
      6'h2b:   return K_ST;
      6'h04:   return K_BEQ;
      6'h03:   return K_JAL;
      default: return K_NONE;
    endcase
  endfunction

  function automatic logic [4:0] m_dst(input logic [31:0] i);
    int k;
    k = k_of(i);
    if (k == K_R) return i[15:11];
    if (k == K_I || k == K_LD) return i[20:16];
    if (k == K_JAL) return 5'd31;
    return 5'd0;
  endfunction

  function automatic bit m_reads(input logic [31:0] i, input logic [4:0] r);
    int k;
    bit rs_src, rt_src;
    k = k_of(i);
    rs_src = (k == K_R || k == K_I || k == K_LD || k == K_ST || k == K_BEQ || k == K_JR);
    rt_src = (k == K_R || k == K_ST || k == K_BEQ);
    if (r == 5'd0) return 1'b0;
    return (rs_src && i[25:21] == r) || (rt_src && i[20:16] == r);
  endfunction

  function automatic bit m_stall_of(input logic [31:0] d, input logic [31:0] e, input logic [31:0] m);
    int kd;
    bit br, al;
    logic [4:0] regs [2];
    kd = k_of(d);
    br = (kd == K_BEQ || kd == K_JR);
    al = (kd == K_R || kd == K_I || kd == K_LD || kd == K_ST);
    regs[0] = d[25:21];
    regs[1] = d[20:16];
    for (int n = 0; n < 2; n++) begin
      if (m_reads(d, regs[n])) begin
        if (br && (m_dst(e) == regs[n] || (k_of(m) == K_LD && m_dst(m) == regs[n]))) return 1'b1;
        if (al && k_of(e) == K_LD && m_dst(e) == regs[n]) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_e = '0; m_m = '0; m_w = '0; m_fm = '0; m_fw = '0; m_cnt = 0; m_stall = 1'b0;
  endtask

  task automatic check_all(input bit exp_stall);
    check_val("stall_D", {31'd0, stall_D}, {31'd0, exp_stall});
    check_val("stall_D_sat", {31'd0, stall2_D}, {31'd0, exp_stall});
    check_val("instrE", instrE, m_e);
    check_val("instrM", instrM, m_m);
    check_val("instrW", instrW, m_w);
    check_val("fwd_data_M", fwd_data_M, m_fm);
    check_val("fwd_data_W", fwd_data_W, m_fw);
    check_val("wdata_W", wdata_W, m_fw);
    check_val("we_W", {31'd0, we_W}, {31'd0, (m_dst(m_w) != 5'd0)});
    check_val("waddr_W", {27'd0, waddr_W}, {27'd0, m_dst(m_w)});
    check_val("stall_cnt", {16'd0, stall_cnt}, (m_cnt > 65535) ? 32'd65535 : m_cnt);
    check_val("stall_cnt_sat", {30'd0, stall2_cnt}, (m_cnt > 3) ? 32'd3 : m_cnt);
  endtask

  // One clock: drive at negedge, compare, then advance the model at the rising edge.
  task automatic step(input logic [31:0] d, input logic [31:0] r, input logic [31:0] md);
    @(negedge clk);
    instrD = d; res_E = r; mem_rdata_M = md;
    #1;
    m_stall = m_stall_of(d, m_e, m_m);
    check_all(m_stall);
    @(posedge clk);
    m_fw = (k_of(m_m) == K_LD) ? md : m_fm;
    m_fm = r;
    m_w  = m_m;
    m_m  = m_e;
    m_e  = m_stall ? 32'd0 : d;
    if (m_stall) m_cnt++;
    #1;
  endtask

  task automatic do_reset(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      rst_n = 1'b0;
      instrD = $urandom; res_E = $urandom; mem_rdata_M = $urandom;
      #1;
      model_reset();
      check_all(1'b0);
    end
    @(negedge clk);
    instrD = '0; res_E = '0; mem_rdata_M = '0;
    rst_n = 1'b1;
    #1;
    check_all(1'b0);
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0] a, b, c;
    a = 5'($urandom_range(0, 3));
    b = 5'($urandom_range(0, 3));
    c = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 10))
      0:  return enc_r(6'h21, a, b, c);
      1:  return enc_r(6'h23, a, b, c);
      2:  return enc_i(6'h0d, a, b, 16'($urandom));
      3:  return enc_i(6'h0f, 5'd0, b, 16'($urandom));
      4:  return enc_i(6'h09, a, b, 16'($urandom));
      5:  return enc_i(6'h23, a, b, 16'($urandom));
      6:  return enc_i(6'h2b, a, b, 16'($urandom));
      7:  return enc_i(6'h04, a, b, 16'($urandom));
      8:  return {6'h03, 26'($urandom)};
      9:  return enc_r(6'h08, (a == 5'd3) ? 5'd31 : a, 5'd0, 5'd0);
      default: return $urandom;
    endcase
  endfunction

  logic [31:0] rd_instr;

  initial begin
    model_reset();

    // Reset held for three cycles with random D.
    do_reset(3);

    // Straight-line ALU ops forward without stalling.
    step(enc_i(6'h0d, 5'd0, 5'd1, 16'd5), 32'd0, 32'd0);
    step(enc_r(6'h21, 5'd1, 5'd1, 5'd2), 32'd5, 32'd0);
    check_val("alu_fwd_M", fwd_data_M, 32'd5);
    step(32'd0, 32'd10, 32'd0);
    check_val("alu_wdata", wdata_W, 32'd5);
    check_val("alu_waddr", {27'd0, waddr_W}, 32'd1);
    check_val("alu_we", {31'd0, we_W}, 32'd1);

    // Load-use: one bubble, then load data reaches W.
    do_reset(1);
    step(enc_i(6'h23, 5'd0, 5'd3, 16'd0), 32'd0, 32'd0);
    step(enc_r(6'h21, 5'd3, 5'd3, 5'd4), 32'd0, 32'd0);
    check_val("lu_bubble", instrE, 32'd0);
    check_val("lu_cnt", {16'd0, stall_cnt}, 32'd1);
    step(enc_r(6'h21, 5'd3, 5'd3, 5'd4), 32'd0, 32'hDEADBEEF);
    check_val("lu_wdata", wdata_W, 32'hDEADBEEF);
    check_val("lu_cnt_after", {16'd0, stall_cnt}, 32'd1);

    // Branch after load: two stall cycles.
    do_reset(1);
    step(enc_i(6'h23, 5'd0, 5'd5, 16'd0), 32'd0, 32'd0);
    step(enc_i(6'h04, 5'd5, 5'd0, 16'd4), 32'd0, 32'd0);
    check_val("br_cnt1", {16'd0, stall_cnt}, 32'd1);
    step(enc_i(6'h04, 5'd5, 5'd0, 16'd4), 32'd0, 32'h1234);
    check_val("br_cnt2", {16'd0, stall_cnt}, 32'd2);
    step(enc_i(6'h04, 5'd5, 5'd0, 16'd4), 32'd0, 32'd0);
    check_val("br_cnt_hold", {16'd0, stall_cnt}, 32'd2);
    check_val("br_issued", instrE, enc_i(6'h04, 5'd5, 5'd0, 16'd4));

    // $0 never creates a dependence or a write.
    do_reset(1);
    step(enc_i(6'h0d, 5'd0, 5'd0, 16'd7), 32'd0, 32'd0);
    step(enc_i(6'h04, 5'd0, 5'd0, 16'd1), 32'd7, 32'd0);
    step(32'd0, 32'd0, 32'd0);
    check_val("zero_cnt", {16'd0, stall_cnt}, 32'd0);
    check_val("zero_we", {31'd0, we_W}, 32'd0);

    // jal then jr $31: one stall, link value forwarded from M.
    do_reset(1);
    step({6'h03, 26'h0000c00}, 32'd0, 32'd0);
    step(enc_r(6'h08, 5'd31, 5'd0, 5'd0), 32'h3008, 32'd0);
    check_val("jal_fwd_M", fwd_data_M, 32'h3008);
    check_val("jal_cnt", {16'd0, stall_cnt}, 32'd1);
    step(enc_r(6'h08, 5'd31, 5'd0, 5'd0), 32'd0, 32'd0);
    check_val("jal_waddr", {27'd0, waddr_W}, 32'd31);
    check_val("jal_wdata", wdata_W, 32'h3008);

    // Five stall cycles: the narrow counter saturates at 3.
    do_reset(1);
    step(enc_i(6'h23, 5'd0, 5'd1, 16'd0), 32'd0, 32'd0);
    for (int n = 0; n < 3; n++) step(enc_i(6'h04, 5'd1, 5'd0, 16'd2), 32'd0, 32'd0);
    step(enc_i(6'h23, 5'd0, 5'd2, 16'd0), 32'd0, 32'd0);
    for (int n = 0; n < 2; n++) step(enc_r(6'h21, 5'd2, 5'd2, 5'd3), 32'd0, 32'd0);
    step(enc_i(6'h23, 5'd0, 5'd3, 16'd0), 32'd0, 32'd0);
    for (int n = 0; n < 3; n++) step(enc_i(6'h04, 5'd3, 5'd0, 16'd2), 32'd0, 32'd0);
    check_val("sat_cnt2", {30'd0, stall2_cnt}, 32'd3);
    check_val("sat_cnt16", {16'd0, stall_cnt}, 32'd5);

    // Reset asserted while a stall is pending clears it immediately.
    do_reset(1);
    step(enc_i(6'h23, 5'd0, 5'd3, 16'd0), 32'd0, 32'd0);
    @(negedge clk);
    instrD = enc_r(6'h21, 5'd3, 5'd3, 5'd4);
    #1;
    check_val("midrst_pre", {31'd0, stall_D}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("midrst_stall", {31'd0, stall_D}, 32'd0);
    check_val("midrst_instrE", instrE, 32'd0);
    model_reset();
    do_reset(1);

    // Randomized traffic; D is held whenever the model predicts a stall.
    do_reset(1);
    rd_instr = '0;
    for (int n = 0; n < 600; n++) begin
      if (!m_stall) rd_instr = rand_instr();
      step(rd_instr, $urandom, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
